// File: rtl/cam_pkg.sv
// Shared types and constants for the camera-bus test-pattern generator:
// frame states, pattern modes and the eight RGB565 color-bar values.
package cam_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } cam_state_e;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_BALL  = 2'd2,
        MODE_RAMP  = 2'd3
    } cam_mode_e;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    // Bar color for bar index 0 (leftmost) .. 7 (rightmost).
    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/cam_stream_gen_if.sv
// OV7670-style parallel pixel bus: pixel clock, frame/line syncs, data byte.
// The generator drives it through the master modport, a capture block reads
// it through the slave modport.
interface cam_stream_gen_if;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] data;

    modport master (output pclk, output vsync, output href, output data);
    modport slave  (input  pclk, input  vsync, input  href, input  data);
endinterface

// File: rtl/cam_pattern_pixel.sv
// Combinational RGB565 color for one pixel of the selected test pattern.
// Ball bounds are compared one bit wider than the coordinates so a ball near
// the right/bottom edge clips instead of wrapping around to column/row 0.
module cam_pattern_pixel
    import cam_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int BALL_SIZE = 32
) (
    input  cam_mode_e   mode,
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    input  logic [15:0] ramp,
    input  logic [9:0]  ball_x,
    input  logic [8:0]  ball_y,
    input  logic [15:0] ball_color,
    output logic [15:0] color
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0]  bar_idx;
    logic [10:0] ball_x_end;
    logic [9:0]  ball_y_end;
    logic        in_ball;

    assign ball_x_end = {1'b0, ball_x} + 11'(BALL_SIZE);
    assign ball_y_end = {1'b0, ball_y} + 10'(BALL_SIZE);
    assign in_ball    = (x >= ball_x) && ({1'b0, x} < ball_x_end) &&
                        (y >= ball_y) && ({1'b0, y} < ball_y_end);

    // Bar index by threshold count, avoiding a divider for non-power-of-2 widths.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x >= 10'(k * BAR_W)) begin
                bar_idx = bar_idx + 3'd1;
            end
        end
    end

    // Pattern select.
    always_comb begin
        color = 16'h0000;
        unique case (mode)
            MODE_BARS:  color = bar_color(bar_idx);
            MODE_SOLID: color = ball_color;
            MODE_BALL:  color = in_ball ? ball_color : 16'h0000;
            MODE_RAMP:  color = ramp;
        endcase
    end

endmodule

// File: rtl/cam_stream_gen.sv
// Camera-side transmitter: pclk divider, line/frame counters, frame FSM and
// registered byte outputs. All bus outputs update only on the clk edge that
// drives pclk low, so they are stable across every pclk rising edge.
module cam_stream_gen
    import cam_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int H_BLANK   = 144,
    parameter int V_SYNC    = 3,
    parameter int V_BACK    = 17,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter int PCLK_HALF = 2,
    parameter int BALL_SIZE = 32
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [9:0]         ball_x,
    input  logic [8:0]         ball_y,
    input  logic [15:0]        ball_color,
    cam_stream_gen_if.master   bus,
    output logic               frame_done
);

    localparam logic [11:0] H_LAST   = 12'(2 * H_ACTIVE + H_BLANK - 1);
    localparam logic [11:0] H_HREF   = 12'(2 * H_ACTIVE);
    localparam logic [15:0] DIV_LAST = 16'(PCLK_HALF - 1);

    cam_state_e  state_q, state_d;
    logic [11:0] h_q, h_d;
    logic [9:0]  v_q, v_d, v_last;
    logic [15:0] div_q;
    logic        pclk_q, tick, step, frame_end, href_d;
    logic        vsync_q, href_q, frame_done_q;
    logic [7:0]  data_q, lo_q;
    logic [15:0] ramp_q, color;
    cam_mode_e   mode_q;
    logic [9:0]  bx_q;
    logic [8:0]  by_q;
    logic [15:0] bc_q;

    // A step is one pclk period boundary: the falling edge while running, or
    // the enable that starts a frame from IDLE (pclk is already low there).
    assign tick = (state_q != IDLE) && (div_q == DIV_LAST);
    assign step = (state_q == IDLE) ? enable : (tick && pclk_q);

    // Pixel clock divider; held low in IDLE, so a stop always ends on a fall.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            div_q  <= '0;
            pclk_q <= 1'b0;
        end else if (state_q == IDLE) begin
            div_q  <= '0;
            pclk_q <= 1'b0;
        end else if (tick) begin
            div_q  <= '0;
            pclk_q <= ~pclk_q;
        end else begin
            div_q  <= div_q + 16'd1;
        end
    end

    // Number of lines in the current vertical region, minus one.
    always_comb begin
        v_last = '0;
        case (state_q)
            VSYNC:   v_last = 10'(V_SYNC - 1);
            VBACK:   v_last = 10'(V_BACK - 1);
            ACTIVE:  v_last = 10'(V_ACTIVE - 1);
            VFRONT:  v_last = 10'(V_FRONT - 1);
            default: v_last = '0;
        endcase
    end

    // Next state and counters for the pclk period that starts at this step.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d   = state_q;
        h_d       = h_q;
        v_d       = v_q;
        frame_end = 1'b0;
        if (step) begin
            if (state_q == IDLE) begin
                state_d = VSYNC;
                h_d     = '0;
                v_d     = '0;
            end else if (h_q != H_LAST) begin
                h_d = h_q + 12'd1;
            end else begin
                h_d = '0;
                if (v_q != v_last) begin
                    v_d = v_q + 10'd1;
                end else begin
                    v_d = '0;
                    case (state_q)
                        VSYNC:  state_d = VBACK;
                        VBACK:  state_d = ACTIVE;
                        ACTIVE: state_d = VFRONT;
                        VFRONT: begin
                            state_d   = enable ? VSYNC : IDLE;
                            frame_end = 1'b1;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        end
    end

    assign href_d = (state_d == ACTIVE) && (h_d < H_HREF);

    // FSM state and h/v position registers.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    // Frame parameters are captured on entry to VSYNC and frozen for the frame.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            mode_q <= MODE_BARS;
            bx_q   <= '0;
            by_q   <= '0;
            bc_q   <= '0;
        end else if (step && state_d == VSYNC && state_q != VSYNC) begin
            mode_q <= cam_mode_e'(mode);
            bx_q   <= ball_x;
            by_q   <= ball_y;
            bc_q   <= ball_color;
        end
    end

    // Color of the pixel whose high byte goes out next.
    cam_pattern_pixel #(
        .H_ACTIVE  (H_ACTIVE),
        .BALL_SIZE (BALL_SIZE)
    ) u_pixel (
        .mode       (mode_q),
        .x          (h_d[10:1]),
        .y          (v_d[8:0]),
        .ramp       (ramp_q),
        .ball_x     (bx_q),
        .ball_y     (by_q),
        .ball_color (bc_q),
        .color      (color)
    );

    // Output registers: high byte goes out directly, low byte is held for the
    // following period; the ramp counter advances once per emitted pixel.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= 8'h00;
            lo_q         <= 8'h00;
            ramp_q       <= 16'h0000;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_end;
            if (step) begin
                vsync_q <= (state_d == VSYNC);
                href_q  <= href_d;
                if (!href_d) begin
                    data_q <= 8'h00;
                end else if (h_d[0]) begin
                    data_q <= lo_q;
                end else begin
                    data_q <= color[15:8];
                    lo_q   <= color[7:0];
                    ramp_q <= ramp_q + 16'd1;
                end
                if (state_d == VSYNC && state_q != VSYNC) begin
                    ramp_q <= 16'h0000;
                end
            end
        end
    end

    assign bus.pclk   = pclk_q;
    assign bus.vsync  = vsync_q;
    assign bus.href   = href_q;
    assign bus.data   = data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Directed bench for cam_stream_gen on a tiny 8x4 frame (H_TOTAL=20,
// 140 pclk periods per frame). Bus values are sampled just after each pclk
// rising edge, as a capture block would see them.
module tb_cam_stream_gen;

    localparam int H_ACTIVE = 8;
    localparam int H_TOTAL  = 20;
    localparam int FRAME    = 140;

    typedef struct packed {
        logic        en;
        logic [1:0]  mode;
        logic [9:0]  bx;
        logic [8:0]  by;
        logic [15:0] bc;
    } cfg_t;

    localparam cfg_t C_BARS     = '{en: 1'b1, mode: 2'd0, bx: 10'd0,   by: 9'd0, bc: 16'h0000};
    localparam cfg_t C_SOLID    = '{en: 1'b1, mode: 2'd1, bx: 10'd0,   by: 9'd0, bc: 16'h1234};
    localparam cfg_t C_BALL     = '{en: 1'b1, mode: 2'd2, bx: 10'd6,   by: 9'd3, bc: 16'hF800};
    localparam cfg_t C_BALL_OUT = '{en: 1'b1, mode: 2'd2, bx: 10'd100, by: 9'd0, bc: 16'hF800};
    localparam cfg_t C_RAMP     = '{en: 1'b1, mode: 2'd3, bx: 10'd0,   by: 9'd0, bc: 16'h0000};
    localparam cfg_t C_RAMP_OFF = '{en: 1'b0, mode: 2'd3, bx: 10'd0,   by: 9'd0, bc: 16'h0000};
    localparam cfg_t C_BARS_OFF = '{en: 1'b0, mode: 2'd0, bx: 10'd0,   by: 9'd0, bc: 16'h0000};

    logic        clk = 1'b0;
    logic        res_n = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [9:0]  ball_x = '0;
    logic [8:0]  ball_y = '0;
    logic [15:0] ball_color = '0;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    cam_stream_gen_if bus ();

    cam_stream_gen #(
        .H_ACTIVE  (8),
        .H_BLANK   (4),
        .V_SYNC    (1),
        .V_BACK    (1),
        .V_ACTIVE  (4),
        .V_FRONT   (1),
        .PCLK_HALF (1),
        .BALL_SIZE (2)
    ) dut (
        .clk        (clk),
        .res_n      (res_n),
        .enable     (enable),
        .mode       (mode),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .ball_color (ball_color),
        .bus        (bus),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic apply_cfg(input cfg_t c);
        enable     = c.en;
        mode       = c.mode;
        ball_x     = c.bx;
        ball_y     = c.by;
        ball_color = c.bc;
    endtask

    // Wait for the next pclk rising edge (bounded), then sit 1 time unit after it.
    task automatic next_rise(output bit ok);
        logic prev;
        prev = bus.pclk;
        ok = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (!prev && bus.pclk) begin
                ok = 1'b1;
                break;
            end
            prev = bus.pclk;
        end
    endtask

    function automatic logic [15:0] exp_color(input cfg_t c, input int x, input int y);
        case (c.mode)
            2'd0: begin
                case (x / (H_ACTIVE / 8))
                    0:       return 16'hFFFF;
                    1:       return 16'hFFE0;
                    2:       return 16'h07FF;
                    3:       return 16'h07E0;
                    4:       return 16'hF81F;
                    5:       return 16'hF800;
                    6:       return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            2'd1: return c.bc;
            2'd2: begin
                if (x >= int'(c.bx) && x < int'(c.bx) + 2 && y >= int'(c.by) && y < int'(c.by) + 2)
                    return c.bc;
                return 16'h0000;
            end
            default: return 16'(y * H_ACTIVE + x);
        endcase
    endfunction

    // Check one whole frame against the model; apply the next frame's
    // configuration mid-frame (sample 50 lies inside the first active line).
    task automatic run_frame(input string tag, input cfg_t cur, input cfg_t nxt, input int fd_before);
        bit          ok;
        int          line, h;
        logic        ev, eh;
        logic [7:0]  ed;
        logic [15:0] c;
        for (int i = 0; i < FRAME; i++) begin
            next_rise(ok);
            if (!ok) begin
                check($sformatf("%s_rise_timeout_%0d", tag, i), 16'd0, 16'd1);
                return;
            end
            line = i / H_TOTAL;
            h    = i % H_TOTAL;
            ev   = (line == 0);
            eh   = (line >= 2) && (line < 6) && (h < 2 * H_ACTIVE);
            ed   = 8'h00;
            if (eh) begin
                c  = exp_color(cur, h / 2, line - 2);
                ed = (h % 2 == 0) ? c[15:8] : c[7:0];
            end
            check($sformatf("%s_vsync_%0d", tag, i), {15'b0, bus.vsync}, {15'b0, ev});
            check($sformatf("%s_href_%0d", tag, i), {15'b0, bus.href}, {15'b0, eh});
            check($sformatf("%s_data_%0d", tag, i), {8'h00, bus.data}, {8'h00, ed});
            if (i == 0) check($sformatf("%s_frame_done_count", tag), 16'(fd_cnt), 16'(fd_before));
            if (i == 50) apply_cfg(nxt);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pclk"}, {15'b0, bus.pclk}, 16'd0);
        check({tag, "_vsync"}, {15'b0, bus.vsync}, 16'd0);
        check({tag, "_href"}, {15'b0, bus.href}, 16'd0);
        check({tag, "_data"}, {8'h00, bus.data}, 16'd0);
        check({tag, "_frame_done"}, {15'b0, frame_done}, 16'd0);
    endtask

    task automatic idle_check(input string tag, input int n);
        int cnt;
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.pclk || bus.vsync || bus.href || (bus.data != 8'h00)) cnt++;
        end
        check(tag, 16'(cnt), 16'd0);
    endtask

    initial begin
        bit found;
        bit ok;

        // Reset state.
        #2 res_n = 1'b0;
        #3 check_outputs_zero("reset");
        @(negedge clk);
        res_n = 1'b1;

        // Disabled: bus stays quiet.
        idle_check("idle_before_enable", 10);

        // Frames 1..6: bars, solid, ball (clipped), ball off-frame, ramp twice.
        @(negedge clk);
        apply_cfg(C_BARS);
        run_frame("f1_bars", C_BARS, C_SOLID, 0);
        run_frame("f2_solid", C_SOLID, C_BALL, 1);
        run_frame("f3_ball", C_BALL, C_BALL_OUT, 2);
        run_frame("f4_ball_out", C_BALL_OUT, C_RAMP, 3);
        run_frame("f5_ramp", C_RAMP, C_RAMP, 4);
        run_frame("f6_ramp_stop", C_RAMP, C_RAMP_OFF, 5);

        // Enable dropped mid-frame: frame completes, one pulse, bus goes quiet.
        repeat (2) @(posedge clk);
        #1;
        check("stop_frame_done_count", 16'(fd_cnt), 16'd6);
        idle_check("idle_after_stop", 40);
        check("stop_no_extra_pulse", 16'(fd_cnt), 16'd6);

        // Reset in the middle of an active line.
        @(negedge clk);
        apply_cfg(C_BARS);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            next_rise(ok);
            if (ok && bus.href) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_href_seen", {15'b0, found}, 16'd1);
        #2 res_n = 1'b0;
        #1 check_outputs_zero("midframe_reset");
        check("midframe_reset_no_pulse", 16'(fd_cnt), 16'd6);
        repeat (3) @(negedge clk);
        res_n = 1'b1;

        // Clean full frame from vsync after release, then stop.
        run_frame("f8_after_reset", C_BARS, C_BARS_OFF, 6);
        repeat (2) @(posedge clk);
        #1;
        check("final_frame_done_count", 16'(fd_cnt), 16'd7);
        idle_check("idle_final", 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_stream_gen.md
# cam_stream_gen

- Synthesizable camera-side transmitter for the OV7670-style parallel pixel bus that the capture path samples: pclk, vsync, href, data.
- Emits RGB565 test frames (color bars, solid color, synthetic ball, pixel-index ramp) with programmable frame geometry.
- Feeds the capture/HSV chain in place of the sensor, giving deterministic ball positions and colors in simulation and on the board.

## Interface
- H_ACTIVE, 640: active pixels per line; must be a multiple of 8.
- H_BLANK, 144: pclk periods with href low after each active line.
- V_SYNC, 3: lines with vsync high.
- V_BACK, 17: blank lines after vsync.
- V_ACTIVE, 480: active lines.
- V_FRONT, 10: blank lines after the active region.
- PCLK_HALF, 2: clk cycles per pclk half-period, ≥1.
- BALL_SIZE, 32: side length of the square ball in pixels.
- clk  in  1  system clock.
- res_n  in  1  asynchronous active-low reset.
- enable  in  1  run frames; level sensitive.
- mode  in  2  pattern: 0 bars, 1 solid ball_color, 2 ball on black, 3 pixel-index ramp.
- ball_x  in  10  ball top-left column.
- ball_y  in  9  ball top-left row.
- ball_color  in  16  RGB565 ball/solid color.
- pclk  out  1  pixel clock.
- vsync  out  1  frame sync, active high.
- href  out  1  line valid, active high.
- data  out  8  pixel byte.
- frame_done  out  1  one-clk pulse at the end of each frame.

## Operation
- States: IDLE → VSYNC (V_SYNC lines) → VBACK (V_BACK lines) → ACTIVE (V_ACTIVE lines) → VFRONT (V_FRONT lines) → VSYNC if enable is high, else IDLE.
- Line length H_TOTAL = 2·H_ACTIVE + H_BLANK pclk periods.
  - In ACTIVE, href is high for the first 2·H_ACTIVE periods and low for the H_BLANK periods.
  - href is low throughout all other states.
- Each pixel takes two pclk periods: high byte first (R[4:0],G[5:3]), then low byte (G[2:0],B[4:0]). data is 0 whenever href is low.
- mode, ball_x, ball_y and ball_color are latched on entry to VSYNC and held constant for the whole frame.
- Pixel (x,y), with x in 0..H_ACTIVE-1 and y in 0..V_ACTIVE-1:
  - bars: bar index = x/(H_ACTIVE/8), colors FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - ball: ball_color if ball_x ≤ x < ball_x+BALL_SIZE and ball_y ≤ y < ball_y+BALL_SIZE, else 0000.
    - Compare in 11/10-bit width so the ball clips at the frame edge without wrapping.
    - A ball entirely outside the frame yields an all-black frame.
  - ramp: value = (y·H_ACTIVE + x) mod 2^16, as a running 16-bit counter cleared at the first pixel of ACTIVE.
- Deasserting enable mid-frame completes the current frame, then goes to IDLE. Asserting enable in IDLE enters VSYNC at the next pclk falling edge.
- frame_done pulses on the clk edge that leaves VFRONT.

## Timing
- Reset values: pclk 0, vsync 0, href 0, data 0, frame_done 0, state IDLE, all counters 0.
- pclk toggles every PCLK_HALF clk cycles and only while not in IDLE. In IDLE it is held low, and a stop always completes the current low phase.
- vsync, href and data change only on the clk edge that drives pclk 1→0. They are stable for a full pclk period around each rising edge.
- A receiver sampling on the pclk rising edge sees the first data byte on the first rising edge after href rises.
- Pixel color is computed one pclk period ahead and registered. There is no extra latency relative to href.
- Reset asserted mid-frame forces all outputs to reset values immediately. After release, the block restarts from IDLE; no partial frame resumes.

## Structure
- Package cam_pkg holds:
  - state enum (IDLE, VSYNC, VBACK, ACTIVE, VFRONT);
  - mode encodings;
  - the eight RGB565 bar constants.
- Sub-module cam_pattern_pixel: combinational (mode, x, y, ramp value, latched ball params) → 16-bit color.
- cam_stream_gen holds the pclk divider, the h/v counters, the FSM, and the byte mux/output registers.

## Test plan
Common parameters: H_ACTIVE=8, H_BLANK=4, V_SYNC=1, V_BACK=1, V_ACTIVE=4, V_FRONT=1, PCLK_HALF=1, BALL_SIZE=2. This gives H_TOTAL=20 and a 140-pclk (280-clk) frame.

1. Reset, then enable=1, mode=0 → vsync high for exactly 20 pclk periods, then 20 periods low before the first href. Sampled bytes per line: FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00. href is low for 4 periods between lines.
2. mode=2, ball_x=6, ball_y=3, ball_color=F800 → only rows 3 and cols 6–7 carry F8,00; every other pixel is 00,00 (clipping at the right and bottom edges).
3. mode=3 → the pixel sequence over one frame is 0000..001F with no gaps. The counter restarts at 0000 in the next frame.
4. mode changed from 0 to 1 mid-frame → the current frame stays bars; the next frame is solid ball_color.
5. enable dropped during ACTIVE → the frame completes, frame_done pulses once, then pclk, vsync and href stay low.
6. res_n pulsed low during ACTIVE → all outputs go to 0 at once. Re-enable gives a clean full frame starting with vsync.
